// File: rtl/arb_pkg.sv
// Shared constants, state encoding and helpers
// for the 4-way round-robin arbiter.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int PTR_W   = 2;
    localparam int HOLD_W  = 8;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    // Index of the set bit in a one-hot (or zero) vector.
    function automatic logic [PTR_W-1:0] oh2idx(
        input logic [NUM_REQ-1:0] oh
    );
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | PTR_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between requesters
// and the round-robin arbiter.
interface rr_arbiter_4_if;
    import arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic               busy;

    modport master (
        output req,
        input  gnt,
        input  busy
    );

    modport slave (
        input  req,
        output gnt,
        output busy
    );

endinterface

// File: rtl/encoder_4to2.sv
// One-hot to binary encoder for the grant
// vector; all-zero input encodes as 0.
module encoder_4to2 (
    input  logic [3:0] in,
    output logic [1:0] out
);

    // Decode the single set bit.
    always_comb begin
        out = 2'd0;
        unique case (1'b1)
            in[0]:   out = 2'd0;
            in[1]:   out = 2'd1;
            in[2]:   out = 2'd2;
            in[3]:   out = 2'd3;
            default: out = 2'd0;
        endcase
    end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set
// request bit scanning upward from ptr.
module rr_pick
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win,
    output logic               valid
);

    // Scan ptr, ptr+1, ... wrapping; first hit wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        win   = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ptr + PTR_W'(k);
            if (!valid && req[idx]) begin
                win[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// 4-way round-robin arbiter with a per-grant
// hold limit and registered one-hot grant.
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input logic           clk,
    input logic           rst_n,
    rr_arbiter_4_if.slave bus
);

    localparam logic [HOLD_W-1:0] MAX_H =
        HOLD_W'(MAX_HOLD);

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [NUM_REQ-1:0] win;
    logic               valid;
    logic [PTR_W-1:0]   cur;
    logic [PTR_W-1:0]   win_idx;
    logic               keep;

    rr_pick u_pick (
        .req   (bus.req),
        .ptr   (ptr),
        .win   (win),
        .valid (valid)
    );

    assign cur     = oh2idx(bus.gnt);
    assign win_idx = oh2idx(win);

    // Current owner keeps the grant while it still
    // asks and its hold budget is not used up.
    // After a grant ptr = owner+1, so re-arbitration
    // gives the owner lowest priority.
    assign keep = (state == GRANT)
               && bus.req[cur]
               && (hold_cnt < MAX_H);

    // Grant FSM: extend, re-arbitrate or go idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            bus.gnt  <= '0;
            bus.busy <= 1'b0;
        end else if (keep) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end else if (valid) begin
            state    <= GRANT;
            bus.gnt  <= win;
            bus.busy <= 1'b1;
            hold_cnt <= HOLD_W'(1);
            ptr      <= win_idx + PTR_W'(1);
        end else begin
            state    <= IDLE;
            bus.gnt  <= '0;
            bus.busy <= 1'b0;
            hold_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4 with
// hold limits 8, 4 and 1.
module tb_rr_arbiter_4;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
    } vec_t;

    typedef struct {
        int         d;
        logic [3:0] g;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] rq [3];
    logic [3:0] gn [3];
    logic       bs [3];
    logic [1:0] en [3];

    int n_chk  = 0;
    int n_fail = 0;

    exp_t sb [$];
    vec_t t8 [9];

    rr_arbiter_4_if bus8 ();
    rr_arbiter_4_if bus4 ();
    rr_arbiter_4_if bus1 ();

    assign bus8.req = rq[0];
    assign bus4.req = rq[1];
    assign bus1.req = rq[2];
    assign gn[0] = bus8.gnt;
    assign gn[1] = bus4.gnt;
    assign gn[2] = bus1.gnt;
    assign bs[0] = bus8.busy;
    assign bs[1] = bus4.busy;
    assign bs[2] = bus1.busy;

    rr_arbiter_4 #(.MAX_HOLD(8)) u8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8)
    );
    rr_arbiter_4 #(.MAX_HOLD(4)) u4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4)
    );
    rr_arbiter_4 #(.MAX_HOLD(1)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    encoder_4to2 e8 (.in(bus8.gnt), .out(en[0]));
    encoder_4to2 e4 (.in(bus4.gnt), .out(en[1]));
    encoder_4to2 e1 (.in(bus1.gnt), .out(en[2]));

    always #5 clk = ~clk;

    function automatic logic [1:0] exp_enc(
        input logic [3:0] g
    );
        case (g)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    task automatic check(
        input string      nm,
        input logic [7:0] act,
        input logic [7:0] exp
    );
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h",
                     nm, act, exp);
        end
    endtask

    // Drive req, queue the expected grant, then
    // compare it one edge later.
    task automatic apply(
        input int         d,
        input logic [3:0] r,
        input logic [3:0] e,
        input string      nm
    );
        exp_t x;
        rq[d] = r;
        sb.push_back('{d: d, g: e});
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check({nm, " gnt"}, {4'h0, gn[x.d]},
              {4'h0, x.g});
        check({nm, " busy"}, {7'h0, bs[x.d]},
              {7'h0, |x.g});
        check({nm, " enc"}, {6'h0, en[x.d]},
              {6'h0, exp_enc(x.g)});
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) rq[i] = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        t8[0] = '{4'b0100, 4'b0100};
        t8[1] = '{4'b0100, 4'b0100};
        t8[2] = '{4'b0000, 4'b0000};
        t8[3] = '{4'b1001, 4'b1000};
        t8[4] = '{4'b0011, 4'b0001};
        t8[5] = '{4'b0110, 4'b0010};
        t8[6] = '{4'b0101, 4'b0100};
        t8[7] = '{4'b0011, 4'b0001};
        t8[8] = '{4'b0000, 4'b0000};

        for (int i = 0; i < 3; i++) rq[i] = 4'b1111;

        // Reset with all requests high, no clock edge.
        #1 rst_n = 1'b0;
        #2;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst gnt%0d", i),
                  {4'h0, gn[i]}, 8'h00);
            check($sformatf("rst busy%0d", i),
                  {7'h0, bs[i]}, 8'h00);
        end
        for (int i = 0; i < 3; i++) rq[i] = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic grant/release and pointer walk.
        for (int i = 0; i < 9; i++) begin
            apply(0, t8[i].req, t8[i].gnt,
                  $sformatf("t8[%0d]", i));
        end

        // Hold limit 8 with two requesters.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            apply(0, 4'b0011,
                  ((i / 8) % 2 == 0) ? 4'b0001
                                     : 4'b0010,
                  $sformatf("hold8[%0d]", i));
        end
        apply(0, 4'b0000, 4'b0000, "hold8 end");

        // Hold limit 1, full rotation.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            apply(2, 4'b1111, 4'b0001 << (i % 4),
                  $sformatf("rot[%0d]", i));
        end

        // Lone requester never sees a gap.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            apply(1, 4'b1000, 4'b1000,
                  $sformatf("lone[%0d]", i));
        end

        // Owner drops on the timeout edge.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply(1, 4'b0110, 4'b0010,
                  $sformatf("drop[%0d]", i));
        end
        apply(1, 4'b1100, 4'b0100, "drop swap");
        apply(1, 4'b1100, 4'b0100, "drop keep");
        apply(1, 4'b0000, 4'b0000, "drop idle");

        // Reset pulse mid-grant restarts at ptr 0.
        do_reset();
        apply(0, 4'b0010, 4'b0010, "mid grant");
        apply(0, 4'b0010, 4'b0010, "mid hold");
        #1 rst_n = 1'b0;
        #1;
        check("mid rst gnt", {4'h0, gn[0]}, 8'h00);
        check("mid rst busy", {7'h0, bs[0]}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        apply(0, 4'b1010, 4'b0010, "post rst");
        apply(0, 4'b0000, 4'b0000, "post idle");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
